// File: rtl/l2sw_pkg.sv
// Shared L2 switch definitions: arbiter state encoding, source indices and fill byte.
package l2sw_pkg;

   localparam int unsigned DATA_W = 8;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_OWN  = 1'b1
   } arb_state_t;

   localparam logic SRC_FWD  = 1'b0;
   localparam logic SRC_CTRL = 1'b1;

   localparam logic [DATA_W-1:0] STALL_FILL = 8'h00;

endpackage

// File: rtl/phy_tx_port_arbiter_if.sv
// Two byte-stream writers plus the merged PHY-TX FIFO write port and error flags.
interface phy_tx_port_arbiter_if;

   logic                          s0_req,   s1_req;
   logic                          s0_gnt,   s1_gnt;
   logic [l2sw_pkg::DATA_W-1:0]   s0_din,   s1_din;
   logic                          s0_del,   s1_del;
   logic                          s0_wren,  s1_wren;
   logic                          s0_afull, s1_afull;
   logic [l2sw_pkg::DATA_W-1:0]   fifo_din;
   logic                          fifo_del;
   logic                          fifo_wren;
   logic                          fifo_afull;
   logic                          err_stray;
   logic                          err_stall;
   logic                          err_clr;

   // Arbiter side.
   modport master (
      input  s0_req, s1_req, s0_din, s1_din, s0_del, s1_del, s0_wren, s1_wren,
      input  fifo_afull, err_clr,
      output s0_gnt, s1_gnt, s0_afull, s1_afull,
      output fifo_din, fifo_del, fifo_wren, err_stray, err_stall
   );

   // Sources and FIFO side.
   modport slave (
      output s0_req, s1_req, s0_din, s1_din, s0_del, s1_del, s0_wren, s1_wren,
      output fifo_afull, err_clr,
      input  s0_gnt, s1_gnt, s0_afull, s1_afull,
      input  fifo_din, fifo_del, fifo_wren, err_stray, err_stall
   );

endinterface

// File: rtl/phy_tx_port_arbiter.sv
// Frame-granular 2:1 arbiter in front of one PHY-TX FIFO, with round-robin tie
// break, stall watchdog and sticky stray/stall error flags.
module phy_tx_port_arbiter
   import l2sw_pkg::*;
#(
   parameter int unsigned STALL_LIMIT = 255
) (
   input logic                   clk,
   input logic                   arst,
   phy_tx_port_arbiter_if.master bus
);

   localparam int unsigned CNT_W = $clog2(STALL_LIMIT + 1);

   arb_state_t state, state_n;
   logic owner, owner_n;
   logic last, last_n;
   logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
   logic [1:0] gnt, gnt_n;
   logic [DATA_W-1:0] fifo_din_q, fifo_din_n;
   logic fifo_del_q, fifo_del_n;
   logic fifo_wren_q, fifo_wren_n;
   logic err_stray_q, err_stray_n;
   logic err_stall_q, err_stall_n;

   logic [1:0] req, wren, del;
   logic [1:0][DATA_W-1:0] din;
   logic win, own_wren, stray_evt, stall_evt;

   assign req  = {bus.s1_req, bus.s0_req};
   assign wren = {bus.s1_wren, bus.s0_wren};
   assign del  = {bus.s1_del, bus.s0_del};
   assign din  = {bus.s1_din, bus.s0_din};

   // Next-state, datapath mux, watchdog and error flags.
   always_comb begin
      state_n     = state;
      owner_n     = owner;
      last_n      = last;
      cnt_n       = cnt;
      gnt_n       = gnt;
      fifo_din_n  = '0;
      fifo_del_n  = 1'b0;
      fifo_wren_n = 1'b0;
      stall_evt   = 1'b0;
      cnt_inc     = cnt + CNT_W'(1);
      own_wren    = wren[owner] & gnt[owner];
      stray_evt   = |(wren & ~gnt);
      win         = (req == 2'b11) ? ((last == SRC_FWD) ? SRC_CTRL : SRC_FWD)
                                   : (req[SRC_CTRL] ? SRC_CTRL : SRC_FWD);

      case (state)
         S_IDLE: begin
            if (!bus.fifo_afull && (|req)) begin
               state_n     = S_OWN;
               owner_n     = win;
               gnt_n       = '0;
               gnt_n[win]  = 1'b1;
               cnt_n       = '0;
            end
         end
         S_OWN: begin
            if (own_wren) begin
               fifo_wren_n = 1'b1;
               fifo_din_n  = din[owner];
               fifo_del_n  = del[owner];
               cnt_n       = '0;
               if (del[owner]) begin
                  gnt_n   = '0;
                  last_n  = owner;
                  state_n = S_IDLE;
               end
            end else if (!bus.fifo_afull) begin
               // Backpressure freezes the count; only true silence advances it.
               if (cnt_inc == CNT_W'(STALL_LIMIT)) begin
                  fifo_wren_n = 1'b1;
                  fifo_din_n  = STALL_FILL;
                  fifo_del_n  = 1'b1;
                  stall_evt   = 1'b1;
                  gnt_n       = '0;
                  state_n     = S_IDLE;
               end else begin
                  cnt_n = cnt_inc;
               end
            end
         end
         default: state_n = S_IDLE;
      endcase

      err_stray_n = stray_evt | (err_stray_q & ~bus.err_clr);
      err_stall_n = stall_evt | (err_stall_q & ~bus.err_clr);
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state       <= S_IDLE;
         owner       <= SRC_FWD;
         last        <= SRC_CTRL;
         cnt         <= '0;
         gnt         <= '0;
         fifo_din_q  <= '0;
         fifo_del_q  <= 1'b0;
         fifo_wren_q <= 1'b0;
         err_stray_q <= 1'b0;
         err_stall_q <= 1'b0;
      end else begin
         state       <= state_n;
         owner       <= owner_n;
         last        <= last_n;
         cnt         <= cnt_n;
         gnt         <= gnt_n;
         fifo_din_q  <= fifo_din_n;
         fifo_del_q  <= fifo_del_n;
         fifo_wren_q <= fifo_wren_n;
         err_stray_q <= err_stray_n;
         err_stall_q <= err_stall_n;
      end
   end

   assign bus.s0_gnt    = gnt[0];
   assign bus.s1_gnt    = gnt[1];
   assign bus.s0_afull  = gnt[0] ? bus.fifo_afull : 1'b1;
   assign bus.s1_afull  = gnt[1] ? bus.fifo_afull : 1'b1;
   assign bus.fifo_din  = fifo_din_q;
   assign bus.fifo_del  = fifo_del_q;
   assign bus.fifo_wren = fifo_wren_q;
   assign bus.err_stray = err_stray_q;
   assign bus.err_stall = err_stall_q;

endmodule

// File: tb/tb_phy_tx_port_arbiter.sv
// Bench for phy_tx_port_arbiter: vector table, directed corner sequences and
// random traffic, all checked every cycle against a frame-level reference model.
module tb_phy_tx_port_arbiter;

   localparam int unsigned LIMIT = 255;

   logic clk;
   logic arst;
   phy_tx_port_arbiter_if bus ();

   phy_tx_port_arbiter #(.STALL_LIMIT(LIMIT)) dut (
      .clk  (clk),
      .arst (arst),
      .bus  (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_tests;
   int n_fail;

   // Reference model: owner is -1 when nobody holds the FIFO.
   int          m_owner;
   int          m_last;
   int          m_silent;
   logic        e_fw, e_fdel, e_es, e_est;
   logic [7:0]  e_fd;
   bit          pend [2];

   typedef struct {
      logic [1:0] rq, wr, dl;
      logic [7:0] x0, x1;
      logic       af, clr;
      logic [1:0] g;
      logic       fw;
      logic [7:0] fd;
      logic       fdel, es;
   } vec_t;

   vec_t tbl [20];

   function automatic vec_t mkv(input int rq, wr, dl, x0, x1, af, clr, g, fw, fd, fdel, es);
      vec_t v;
      v.rq = 2'(rq); v.wr = 2'(wr); v.dl = 2'(dl);
      v.x0 = 8'(x0); v.x1 = 8'(x1);
      v.af = 1'(af); v.clr = 1'(clr);
      v.g = 2'(g); v.fw = 1'(fw); v.fd = 8'(fd); v.fdel = 1'(fdel); v.es = 1'(es);
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void m_reset();
      m_owner  = -1;
      m_last   = 1;
      m_silent = 0;
      e_fw = 1'b0; e_fdel = 1'b0; e_fd = 8'h00; e_es = 1'b0; e_est = 1'b0;
   endfunction

   // One clock of the frame-level rules, applied to the inputs about to be sampled.
   function automatic void model_step();
      logic [1:0] rq, wr, dl;
      logic [7:0] dn [2];
      bit stray, stall;
      rq = {bus.s1_req, bus.s0_req};
      wr = {bus.s1_wren, bus.s0_wren};
      dl = {bus.s1_del, bus.s0_del};
      dn[0] = bus.s0_din;
      dn[1] = bus.s1_din;
      stray = 1'b0;
      stall = 1'b0;
      e_fw = 1'b0; e_fd = 8'h00; e_fdel = 1'b0;
      for (int s = 0; s < 2; s++)
         if (wr[s] && m_owner != s) stray = 1'b1;
      if (m_owner < 0) begin
         if (!bus.fifo_afull && rq != 2'b00) begin
            if (rq == 2'b11) m_owner = 1 - m_last;
            else             m_owner = rq[1] ? 1 : 0;
            m_silent = 0;
         end
      end else if (wr[m_owner]) begin
         e_fw = 1'b1; e_fd = dn[m_owner]; e_fdel = dl[m_owner];
         m_silent = 0;
         if (dl[m_owner]) begin
            m_last  = m_owner;
            m_owner = -1;
         end
      end else if (!bus.fifo_afull) begin
         m_silent++;
         if (m_silent == int'(LIMIT)) begin
            e_fw = 1'b1; e_fd = 8'h00; e_fdel = 1'b1;
            stall   = 1'b1;
            m_owner = -1;
         end
      end
      e_es  = stray || (e_es && !bus.err_clr);
      e_est = stall || (e_est && !bus.err_clr);
   endfunction

   task automatic check_all();
      chk("s0_gnt",    32'(bus.s0_gnt),    32'(m_owner == 0));
      chk("s1_gnt",    32'(bus.s1_gnt),    32'(m_owner == 1));
      chk("s0_afull",  32'(bus.s0_afull),  32'((m_owner == 0) ? bus.fifo_afull : 1'b1));
      chk("s1_afull",  32'(bus.s1_afull),  32'((m_owner == 1) ? bus.fifo_afull : 1'b1));
      chk("fifo_wren", 32'(bus.fifo_wren), 32'(e_fw));
      chk("fifo_din",  32'(bus.fifo_din),  32'(e_fd));
      chk("fifo_del",  32'(bus.fifo_del),  32'(e_fdel));
      chk("err_stray", 32'(bus.err_stray), 32'(e_es));
      chk("err_stall", 32'(bus.err_stall), 32'(e_est));
   endtask

   // Called at a falling edge with inputs set; returns at the next falling edge.
   task automatic tick();
      model_step();
      @(negedge clk);
      check_all();
   endtask

   task automatic idle_in();
      bus.s0_req = 1'b0; bus.s1_req = 1'b0;
      bus.s0_wren = 1'b0; bus.s1_wren = 1'b0;
      bus.s0_del = 1'b0; bus.s1_del = 1'b0;
      bus.s0_din = 8'h00; bus.s1_din = 8'h00;
      bus.fifo_afull = 1'b0; bus.err_clr = 1'b0;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, ".s0_gnt"},    32'(bus.s0_gnt),    32'(0));
      chk({tag, ".s1_gnt"},    32'(bus.s1_gnt),    32'(0));
      chk({tag, ".s0_afull"},  32'(bus.s0_afull),  32'(1));
      chk({tag, ".s1_afull"},  32'(bus.s1_afull),  32'(1));
      chk({tag, ".fifo_din"},  32'(bus.fifo_din),  32'(0));
      chk({tag, ".fifo_del"},  32'(bus.fifo_del),  32'(0));
      chk({tag, ".fifo_wren"}, 32'(bus.fifo_wren), 32'(0));
      chk({tag, ".err_stray"}, 32'(bus.err_stray), 32'(0));
      chk({tag, ".err_stall"}, 32'(bus.err_stall), 32'(0));
   endtask

   task automatic do_reset();
      idle_in();
      arst = 1'b1;
      #1;
      m_reset();
      pend[0] = 1'b0;
      pend[1] = 1'b0;
      @(negedge clk);
      arst = 1'b0;
   endtask

   task automatic rand_drive();
      logic [1:0] rq, wr, dl, gs;
      logic [7:0] dn [2];
      if ($urandom_range(0, 7) == 0) bus.fifo_afull = ~bus.fifo_afull;
      bus.err_clr = ($urandom_range(0, 29) == 0);
      gs = {bus.s1_gnt, bus.s0_gnt};
      for (int s = 0; s < 2; s++) begin
         dn[s] = 8'($urandom);
         if (gs[s]) begin
            pend[s] = 1'b0;
            rq[s] = 1'b0;
            wr[s] = !bus.fifo_afull && ($urandom_range(0, 2) != 0);
            dl[s] = wr[s] && ($urandom_range(0, 5) == 0);
         end else begin
            if (!pend[s]) pend[s] = ($urandom_range(0, 3) == 0);
            rq[s] = pend[s];
            wr[s] = ($urandom_range(0, 49) == 0);
            dl[s] = wr[s] && ($urandom_range(0, 1) == 0);
         end
      end
      bus.s0_req = rq[0]; bus.s0_wren = wr[0]; bus.s0_del = dl[0]; bus.s0_din = dn[0];
      bus.s1_req = rq[1]; bus.s1_wren = wr[1]; bus.s1_del = dl[1]; bus.s1_din = dn[1];
   endtask

   initial begin
      int n;
      n_tests = 0;
      n_fail  = 0;
      arst    = 1'b0;
      idle_in();
      m_reset();
      pend[0] = 1'b0;
      pend[1] = 1'b0;
      #1 arst = 1'b1;
      #1 chk_reset("reset");
      @(negedge clk);
      arst = 1'b0;

      // rq/wr/dl/g are {s1,s0}: tie, alternation, single-source frame, idle backpressure, stray.
      tbl[0]  = mkv(3, 0, 0, 'h00, 'h00, 0, 0, 1, 0, 'h00, 0, 0);
      tbl[1]  = mkv(2, 1, 0, 'hB0, 'h00, 0, 0, 1, 1, 'hB0, 0, 0);
      tbl[2]  = mkv(2, 1, 1, 'hB1, 'h00, 0, 0, 0, 1, 'hB1, 1, 0);
      tbl[3]  = mkv(3, 0, 0, 'h00, 'h00, 0, 0, 2, 0, 'h00, 0, 0);
      tbl[4]  = mkv(1, 2, 2, 'h00, 'hC0, 0, 0, 0, 1, 'hC0, 1, 0);
      tbl[5]  = mkv(1, 0, 0, 'h00, 'h00, 0, 0, 1, 0, 'h00, 0, 0);
      tbl[6]  = mkv(0, 1, 1, 'hD0, 'h00, 0, 0, 0, 1, 'hD0, 1, 0);
      tbl[7]  = mkv(2, 0, 0, 'h00, 'h00, 0, 0, 2, 0, 'h00, 0, 0);
      tbl[8]  = mkv(0, 2, 0, 'h00, 'hA0, 0, 0, 2, 1, 'hA0, 0, 0);
      tbl[9]  = mkv(0, 2, 0, 'h00, 'hA1, 0, 0, 2, 1, 'hA1, 0, 0);
      tbl[10] = mkv(0, 2, 0, 'h00, 'hA2, 0, 0, 2, 1, 'hA2, 0, 0);
      tbl[11] = mkv(0, 2, 2, 'h00, 'hA3, 0, 0, 0, 1, 'hA3, 1, 0);
      tbl[12] = mkv(1, 0, 0, 'h00, 'h00, 1, 0, 0, 0, 'h00, 0, 0);
      tbl[13] = mkv(1, 0, 0, 'h00, 'h00, 1, 0, 0, 0, 'h00, 0, 0);
      tbl[14] = mkv(1, 0, 0, 'h00, 'h00, 0, 0, 1, 0, 'h00, 0, 0);
      tbl[15] = mkv(0, 1, 1, 'hE0, 'h00, 0, 0, 0, 1, 'hE0, 1, 0);
      tbl[16] = mkv(0, 2, 0, 'h00, 'h77, 0, 0, 0, 0, 'h00, 0, 1);
      tbl[17] = mkv(0, 0, 0, 'h00, 'h00, 0, 1, 0, 0, 'h00, 0, 0);
      tbl[18] = mkv(0, 1, 0, 'h11, 'h00, 0, 1, 0, 0, 'h00, 0, 1);
      tbl[19] = mkv(0, 0, 0, 'h00, 'h00, 0, 1, 0, 0, 'h00, 0, 0);

      for (int i = 0; i < 20; i++) begin
         bus.s0_req = tbl[i].rq[0];  bus.s1_req = tbl[i].rq[1];
         bus.s0_wren = tbl[i].wr[0]; bus.s1_wren = tbl[i].wr[1];
         bus.s0_del = tbl[i].dl[0];  bus.s1_del = tbl[i].dl[1];
         bus.s0_din = tbl[i].x0;     bus.s1_din = tbl[i].x1;
         bus.fifo_afull = tbl[i].af; bus.err_clr = tbl[i].clr;
         tick();
         chk($sformatf("vec%0d.gnt", i),  32'({bus.s1_gnt, bus.s0_gnt}), 32'(tbl[i].g));
         chk($sformatf("vec%0d.wren", i), 32'(bus.fifo_wren), 32'(tbl[i].fw));
         if (tbl[i].fw)
            chk($sformatf("vec%0d.din", i), 32'(bus.fifo_din), 32'(tbl[i].fd));
         chk($sformatf("vec%0d.del", i),  32'(bus.fifo_del), 32'(tbl[i].fdel));
         chk($sformatf("vec%0d.stray", i), 32'(bus.err_stray), 32'(tbl[i].es));
      end

      // Long backpressure while owning must not trip the watchdog.
      do_reset();
      bus.s0_req = 1'b1;
      tick();
      bus.s0_req = 1'b0;
      bus.fifo_afull = 1'b1;
      repeat (300) tick();
      chk("bp.s0_afull", 32'(bus.s0_afull), 32'(1));
      chk("bp.s0_gnt", 32'(bus.s0_gnt), 32'(1));
      chk("bp.err_stall", 32'(bus.err_stall), 32'(0));
      bus.fifo_afull = 1'b0;
      bus.s0_wren = 1'b1; bus.s0_din = 8'h3C; bus.s0_del = 1'b1;
      tick();
      chk("bp.last_del", 32'({bus.fifo_wren, bus.fifo_del, bus.fifo_din}), 32'({1'b1, 1'b1, 8'h3C}));
      idle_in();

      // Stall: two bytes then silence until the fill byte.
      bus.s0_req = 1'b1;
      tick();
      bus.s0_req = 1'b0;
      bus.s0_wren = 1'b1; bus.s0_din = 8'h21;
      tick();
      bus.s0_din = 8'h22;
      tick();
      bus.s0_wren = 1'b0;
      n = 0;
      do begin
         tick();
         n++;
      end while (!bus.fifo_wren && n < 400);
      chk("stall.cycles", 32'(n), 32'(LIMIT));
      chk("stall.fill", 32'({bus.fifo_din, bus.fifo_del}), 32'({8'h00, 1'b1}));
      chk("stall.err", 32'(bus.err_stall), 32'(1));
      chk("stall.gnt", 32'(bus.s0_gnt), 32'(0));
      bus.s0_wren = 1'b1; bus.s0_din = 8'h23;
      tick();
      chk("stall.late_wr", 32'({bus.fifo_wren, bus.err_stray}), 32'({1'b0, 1'b1}));
      idle_in();

      // Stray from s1 while s0 owns, alongside and without an s0 write.
      do_reset();
      bus.s0_req = 1'b1;
      tick();
      bus.s0_req = 1'b0;
      bus.s0_wren = 1'b1; bus.s0_din = 8'h10;
      bus.s1_wren = 1'b1; bus.s1_din = 8'h5A;
      tick();
      chk("stray.keep_owner", 32'({bus.fifo_wren, bus.fifo_din}), 32'({1'b1, 8'h10}));
      chk("stray.flag", 32'(bus.err_stray), 32'(1));
      idle_in();
      bus.err_clr = 1'b1;
      tick();
      chk("stray.clr", 32'(bus.err_stray), 32'(0));
      bus.err_clr = 1'b0;
      bus.s1_wren = 1'b1; bus.s1_din = 8'h5B;
      tick();
      chk("stray.drop", 32'({bus.fifo_wren, bus.err_stray}), 32'({1'b0, 1'b1}));
      idle_in();
      bus.s0_wren = 1'b1; bus.s0_del = 1'b1; bus.s0_din = 8'h11;
      tick();
      idle_in();

      // Reset in the middle of a frame.
      bus.s0_req = 1'b1;
      tick();
      bus.s0_req = 1'b0;
      bus.s0_wren = 1'b1;
      for (int b = 0; b < 3; b++) begin
         bus.s0_din = 8'(8'h40 + b);
         tick();
      end
      arst = 1'b1;
      #1 chk_reset("midrst");
      idle_in();
      m_reset();
      pend[0] = 1'b0;
      pend[1] = 1'b0;
      #2 arst = 1'b0;
      bus.s1_req = 1'b1;
      tick();
      chk("midrst.regrant", 32'(bus.s1_gnt), 32'(1));
      idle_in();

      // Random traffic against the model.
      do_reset();
      repeat (3000) begin
         rand_drive();
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
